// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multicycle MIPS control slice.
// Holds opcode/function encodings, ALU operation codes, PC source codes,
// the instruction class enum produced by mc_decode and the FSM state enum.
package mips_pkg;

   // Opcodes (instruction bits 31:26)
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function field (instruction bits 5:0)
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLTU = 6'b101011;
   localparam logic [5:0] FN_SLLV = 6'b000100;

   // ALU operation codes (zero-extended to ALU_OP_W at the top level)
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_NOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLLV = 3'b111;

   // PC source select
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_ALUI,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_J
   } cls_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//   op      in  6 : opcode
//   func    in  6 : R-type function field
//   cls     out   : instruction class (R, ALU-immediate, lw, sw, beq, j)
//   alu     out 3 : ALU operation code for the instruction
//   illegal out 1 : opcode/func combination not supported
// With ITYPE_EN = 0 only R-type (op = 0) instructions are legal.
module mc_decode
   import mips_pkg::*;
#(
   parameter bit ITYPE_EN = 1'b1
) (
   input  logic [5:0] op,
   input  logic [5:0] func,
   output cls_t       cls,
   output logic [2:0] alu,
   output logic       illegal
);

   always_comb begin
      cls     = CLS_R;
      alu     = ALU_ADD;
      illegal = 1'b0;
      if (op == OP_RTYPE) begin
         unique case (func)
            FN_ADD:  alu = ALU_ADD;
            FN_SUB:  alu = ALU_SUB;
            FN_AND:  alu = ALU_AND;
            FN_OR:   alu = ALU_OR;
            FN_XOR:  alu = ALU_XOR;
            FN_NOR:  alu = ALU_NOR;
            FN_SLTU: alu = ALU_SLTU;
            FN_SLLV: alu = ALU_SLLV;
            default: illegal = 1'b1;
         endcase
      end else if (!ITYPE_EN) begin
         illegal = 1'b1;
      end else begin
         unique case (op)
            OP_ADDI: begin cls = CLS_ALUI; alu = ALU_ADD; end
            OP_ANDI: begin cls = CLS_ALUI; alu = ALU_AND; end
            OP_ORI:  begin cls = CLS_ALUI; alu = ALU_OR;  end
            OP_XORI: begin cls = CLS_ALUI; alu = ALU_XOR; end
            OP_LW:   begin cls = CLS_LW;   alu = ALU_ADD; end
            OP_SW:   begin cls = CLS_SW;   alu = ALU_ADD; end
            OP_BEQ:  begin cls = CLS_BEQ;  alu = ALU_SUB; end
            OP_J:    begin cls = CLS_J;    alu = ALU_AND; end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control unit.
// Sequences each instruction through FETCH, DECODE, EXEC/ADDR, MEM and WB,
// with a bounded memory wait (timeout -> bus-error trap) and an
// illegal-instruction trap held until trap_ack.
//   clk, rst_n                  : clock, synchronous active-low reset
//   OP, func                    : instruction fields from the IR
//   zero                        : ALU zero flag (beq)
//   mem_ready                   : memory completes the current access
//   trap_ack                    : leaves TRAP (ignored elsewhere)
//   PC_WE, IR_WE, REG_WE        : datapath register enables
//   MEM_RE, MEM_WE              : memory read/write strobes
//   ALU_OP                      : ALU operation (zero-extended code)
//   ALU_SRC_B, REG_DST, MEM_TO_REG : mux selects
//   PC_SRC                      : 0 PC+4, 1 branch target, 2 jump target
//   retire                      : one pulse per completed instruction
//   trap, bus_err               : trap active / cause is memory timeout
module mc_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned ALU_OP_W    = 3,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter bit          ITYPE_EN    = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          OP,
   input  logic [5:0]          func,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                trap_ack,
   output logic                PC_WE,
   output logic                IR_WE,
   output logic                REG_WE,
   output logic                MEM_RE,
   output logic                MEM_WE,
   output logic [ALU_OP_W-1:0] ALU_OP,
   output logic                ALU_SRC_B,
   output logic                REG_DST,
   output logic                MEM_TO_REG,
   output logic [1:0]          PC_SRC,
   output logic                retire,
   output logic                trap,
   output logic                bus_err
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   logic [5:0] op_q;
   logic [5:0] func_q;
   logic [7:0] wait_cnt;
   logic       bus_err_q;

   logic [5:0] dec_op;
   logic [5:0] dec_func;
   cls_t       dec_cls;
   logic [2:0] dec_alu;
   logic       dec_illegal;
   logic       timeout_hit;
   logic [2:0] alu_sel;

   // One decoder serves both the DECODE branch (live IR fields) and the
   // later states (latched fields), so IR changes after DECODE are ignored.
   assign dec_op   = (state == S_DECODE) ? OP   : op_q;
   assign dec_func = (state == S_DECODE) ? func : func_q;

   mc_decode #(
      .ITYPE_EN (ITYPE_EN)
   ) u_decode (
      .op      (dec_op),
      .func    (dec_func),
      .cls     (dec_cls),
      .alu     (dec_alu),
      .illegal (dec_illegal)
   );

   // Last permitted wait cycle with memory still not ready.
   assign timeout_hit = !mem_ready && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= '0;
         func_q    <= '0;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         // Counter runs only while stalled in a memory state; any exit
         // clears it, which is equivalent to clearing on entry.
         wait_cnt <= '0;
         unique case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
               if (mem_ready) begin
                  unique case (state)
                     S_FETCH:  state <= S_DECODE;
                     S_MEM_RD: state <= S_WB;
                     default:  state <= S_FETCH;
                  endcase
               end else if (timeout_hit) begin
                  state     <= S_TRAP;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               op_q   <= OP;
               func_q <= func;
               if (dec_illegal) begin
                  state <= S_TRAP;
               end else begin
                  unique case (dec_cls)
                     CLS_R:         state <= S_EXEC_R;
                     CLS_ALUI:      state <= S_EXEC_I;
                     CLS_LW, CLS_SW: state <= S_ADDR;
                     CLS_BEQ:       state <= S_BRANCH;
                     CLS_J:         state <= S_JUMP;
                     default:       state <= S_TRAP;
                  endcase
               end
            end
            S_EXEC_R, S_EXEC_I: state <= S_WB;
            S_ADDR: state <= (dec_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
            S_TRAP: begin
               if (trap_ack) begin
                  state     <= S_IDLE;
                  bus_err_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      PC_WE      = 1'b0;
      IR_WE      = 1'b0;
      REG_WE     = 1'b0;
      MEM_RE     = 1'b0;
      MEM_WE     = 1'b0;
      alu_sel    = ALU_AND;
      ALU_SRC_B  = 1'b0;
      REG_DST    = 1'b0;
      MEM_TO_REG = 1'b0;
      PC_SRC     = PC_PLUS4;
      retire     = 1'b0;
      trap       = 1'b0;
      bus_err    = 1'b0;
      unique case (state)
         S_FETCH: begin
            MEM_RE = 1'b1;
            IR_WE  = mem_ready;
            PC_WE  = mem_ready;
         end
         S_EXEC_R: alu_sel = dec_alu;
         S_EXEC_I: begin
            alu_sel   = dec_alu;
            ALU_SRC_B = 1'b1;
         end
         S_ADDR: begin
            alu_sel   = ALU_ADD;
            ALU_SRC_B = 1'b1;
         end
         S_MEM_RD: MEM_RE = 1'b1;
         S_MEM_WR: begin
            MEM_WE = 1'b1;
            retire = mem_ready;
         end
         S_WB: begin
            REG_WE     = 1'b1;
            REG_DST    = (dec_cls == CLS_R);
            MEM_TO_REG = (dec_cls == CLS_LW);
            retire     = 1'b1;
         end
         S_BRANCH: begin
            alu_sel = ALU_SUB;
            if (zero) begin
               PC_SRC = PC_BRANCH;
               PC_WE  = 1'b1;
            end
            retire = 1'b1;
         end
         S_JUMP: begin
            PC_SRC = PC_JUMP;
            PC_WE  = 1'b1;
            retire = 1'b1;
         end
         S_TRAP: begin
            trap    = 1'b1;
            bus_err = bus_err_q;
         end
         default: ;
      endcase
      ALU_OP = ALU_OP_W'(alu_sel);
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each step advances one clock, applies the
// per-cycle inputs and compares every output against hand-derived values.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] OP;
   logic [5:0] func;
   logic       zero;
   logic       mem_ready;
   logic       trap_ack;
   logic       PC_WE, IR_WE, REG_WE, MEM_RE, MEM_WE;
   logic [2:0] ALU_OP;
   logic       ALU_SRC_B, REG_DST, MEM_TO_REG;
   logic [1:0] PC_SRC;
   logic       retire, trap, bus_err;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // Enable-vector bit masks: {PC_WE,IR_WE,REG_WE,MEM_RE,MEM_WE,ALU_SRC_B,
   // REG_DST,MEM_TO_REG,retire,trap,bus_err}
   localparam logic [10:0] NONE  = 11'h000;
   localparam logic [10:0] PCWE  = 11'h400;
   localparam logic [10:0] IRWE  = 11'h200;
   localparam logic [10:0] REGWE = 11'h100;
   localparam logic [10:0] MEMRE = 11'h080;
   localparam logic [10:0] MEMWE = 11'h040;
   localparam logic [10:0] SRCB  = 11'h020;
   localparam logic [10:0] DST   = 11'h010;
   localparam logic [10:0] M2R   = 11'h008;
   localparam logic [10:0] RET   = 11'h004;
   localparam logic [10:0] TRP   = 11'h002;
   localparam logic [10:0] BERR  = 11'h001;
   localparam logic [10:0] FETCH_OK = MEMRE | IRWE | PCWE;

   always #5 clk = ~clk;

   mc_ctrl #(
      .ALU_OP_W    (3),
      .MEM_TIMEOUT (4),
      .ITYPE_EN    (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .OP         (OP),
      .func       (func),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .trap_ack   (trap_ack),
      .PC_WE      (PC_WE),
      .IR_WE      (IR_WE),
      .REG_WE     (REG_WE),
      .MEM_RE     (MEM_RE),
      .MEM_WE     (MEM_WE),
      .ALU_OP     (ALU_OP),
      .ALU_SRC_B  (ALU_SRC_B),
      .REG_DST    (REG_DST),
      .MEM_TO_REG (MEM_TO_REG),
      .PC_SRC     (PC_SRC),
      .retire     (retire),
      .trap       (trap),
      .bus_err    (bus_err)
   );

   task automatic cyc(input string tag, input logic mr, input logic z,
                      input logic ack, input logic [10:0] en,
                      input logic [2:0] alu, input logic [1:0] pcs);
      logic [15:0] obs;
      logic [15:0] exp;
      @(posedge clk);
      #1;
      mem_ready = mr;
      zero      = z;
      trap_ack  = ack;
      #2;
      obs = {PC_WE, IR_WE, REG_WE, MEM_RE, MEM_WE, ALU_SRC_B, REG_DST,
             MEM_TO_REG, retire, trap, bus_err, ALU_OP, PC_SRC};
      exp = {en, alu, pcs};
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; OP = 6'b000000; func = 6'b100000;
      mem_ready = 1'b1; zero = 1'b0; trap_ack = 1'b0;

      cyc("rst_a", 1, 0, 0, NONE, 3'b000, 2'd0);
      cyc("rst_b", 1, 0, 0, NONE, 3'b000, 2'd0);
      rst_n = 1'b1;

      // R-type add; IR fields scrambled after DECODE must not matter
      cyc("add_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("add_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("add_exec",  1, 0, 0, NONE,     3'b100, 2'd0);
      OP = 6'b111111; func = 6'b111111;
      cyc("add_wb",    1, 0, 0, REGWE | DST | RET, 3'b000, 2'd0);

      // lw with three wait cycles in MEM_RD (last one at the limit)
      OP = 6'b100011;
      cyc("lw_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("lw_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("lw_addr",  1, 0, 0, SRCB,     3'b100, 2'd0);
      cyc("lw_wait1", 0, 0, 0, MEMRE,    3'b000, 2'd0);
      cyc("lw_wait2", 0, 0, 0, MEMRE,    3'b000, 2'd0);
      cyc("lw_wait3", 0, 0, 0, MEMRE,    3'b000, 2'd0);
      cyc("lw_rdy",   1, 0, 0, MEMRE,    3'b000, 2'd0);
      cyc("lw_wb",    1, 0, 0, REGWE | M2R | RET, 3'b000, 2'd0);

      // sw
      OP = 6'b101011;
      cyc("sw_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("sw_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("sw_addr",  1, 0, 0, SRCB,     3'b100, 2'd0);
      cyc("sw_mem",   1, 0, 0, MEMWE | RET, 3'b000, 2'd0);

      // beq taken, then not taken
      OP = 6'b000100;
      cyc("beq1_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("beq1_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("beq_taken",  1, 1, 0, PCWE | RET, 3'b101, 2'd1);
      cyc("beq2_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("beq2_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("beq_not",    1, 0, 0, RET,      3'b101, 2'd0);

      // j, with a stray trap_ack that must be ignored
      OP = 6'b000010;
      cyc("j_fetch", 1, 0, 1, FETCH_OK, 3'b000, 2'd0);
      cyc("j_dec",   1, 0, 1, NONE,     3'b000, 2'd0);
      cyc("j_jump",  1, 0, 1, PCWE | RET, 3'b000, 2'd2);

      // ori
      OP = 6'b001101;
      cyc("ori_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("ori_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("ori_exec",  1, 0, 0, SRCB,     3'b001, 2'd0);
      cyc("ori_wb",    1, 0, 0, REGWE | RET, 3'b000, 2'd0);

      // R-type sltu
      OP = 6'b000000; func = 6'b101011;
      cyc("sltu_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("sltu_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("sltu_exec",  1, 0, 0, NONE,     3'b110, 2'd0);
      cyc("sltu_wb",    1, 0, 0, REGWE | DST | RET, 3'b000, 2'd0);

      // Illegal func: trap holds until acknowledged
      func = 6'b000000;
      cyc("ill_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("ill_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("ill_trap",  0, 0, 0, TRP,      3'b000, 2'd0);
      for (int i = 0; i < 5; i++) cyc("ill_hold", 0, 0, 0, TRP, 3'b000, 2'd0);
      cyc("ill_ack",   1, 0, 1, TRP,      3'b000, 2'd0);
      cyc("ill_idle",  1, 0, 0, NONE,     3'b000, 2'd0);

      // Illegal opcode
      OP = 6'b001111;
      cyc("iop_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("iop_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("iop_trap",  1, 0, 0, TRP,      3'b000, 2'd0);
      cyc("iop_ack",   1, 0, 1, TRP,      3'b000, 2'd0);
      cyc("iop_idle",  1, 0, 0, NONE,     3'b000, 2'd0);

      // FETCH timeout: four unready cycles then bus-error trap
      OP = 6'b000000; func = 6'b100000;
      for (int i = 0; i < 4; i++) cyc("to_wait", 0, 0, 0, MEMRE, 3'b000, 2'd0);
      cyc("to_trap", 0, 0, 0, TRP | BERR, 3'b000, 2'd0);
      cyc("to_ack",  0, 0, 1, TRP | BERR, 3'b000, 2'd0);
      cyc("to_idle", 0, 0, 0, NONE,       3'b000, 2'd0);

      // Ready on the last allowed cycle wins over the timeout
      for (int i = 0; i < 3; i++) cyc("nt_wait", 0, 0, 0, MEMRE, 3'b000, 2'd0);
      cyc("nt_rdy",  1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("nt_dec",  1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("nt_exec", 1, 0, 0, NONE,     3'b100, 2'd0);
      cyc("nt_wb",   1, 0, 0, REGWE | DST | RET, 3'b000, 2'd0);

      // Reset during MEM_WR aborts without retire
      OP = 6'b101011;
      cyc("rs_fetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);
      cyc("rs_dec",   1, 0, 0, NONE,     3'b000, 2'd0);
      cyc("rs_addr",  1, 0, 0, SRCB,     3'b100, 2'd0);
      cyc("rs_memwr", 0, 0, 0, MEMWE,    3'b000, 2'd0);
      rst_n = 1'b0;
      cyc("rs_abort", 1, 0, 0, NONE,     3'b000, 2'd0);
      rst_n = 1'b1;
      cyc("rs_refetch", 1, 0, 0, FETCH_OK, 3'b000, 2'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
